alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single registered `alu` between two requesters: requester 0, the execute stage, and requester 1, the branch/compare unit. It uses round-robin arbitration and valid/ready handshakes, and routes each one-cycle-latency ALU result back to the requester that issued it. Per-requester response holding lets a stalled consumer keep its result without blocking the other requester.

## Interface
- `XLEN`, 32, operand/result width; must match `alu` (32).
- `FIRST_PRIO`, 0, requester that wins the first contended cycle after reset.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, bit i = requester i.
- `req_ready` out 2: request accepted this cycle (grant), bit i = requester i.
- `req_op0`, `req_op1` in 4: ALU opcode from the shared opcode codes; passed through undecoded.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in XLEN: operands.
- `alu_op` out 4: opcode to `alu`.
- `alu_a`, `alu_b` out XLEN: operands to `alu`.
- `alu_res` in XLEN: registered `alu` result, valid the cycle after issue.
- `rsp_valid` out 2: result available, bit i = requester i.
- `rsp_ready` in 2: requester i consumes its result.
- `rsp_data0`, `rsp_data1` out XLEN: results.

## Operation
- Eligibility:
  - `elig_i = req_valid[i] & ~held_i & ~(inflight_i & ~rsp_ready[i])`.
  - A requester gets at most one outstanding result.
- Grant:
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant `~last`. `last` is the most recently granted index; reset value is `~FIRST_PRIO`.
  - `req_ready` is one-hot or zero and is combinational from `req_valid`, `rsp_ready` and state.
- Issue: in the grant cycle, `alu_op`/`alu_a`/`alu_b` are driven combinationally from the granted requester.
- Idle cycles (no grant): drive `alu_op` = ADD and `alu_a` = `alu_b` = 0. The result is discarded.
- State:
  - `inflight` register: valid bit plus 1-bit id, set at the grant edge.
  - Per requester, a hold slot: `held_i` plus `data_i`.
- Response cycle (the cycle after grant, `inflight` set with id = i):
  - `rsp_valid[i]` = 1 and `rsp_data_i` = `alu_res` (bypass).
  - If `rsp_ready[i]` = 0 at that edge: `data_i` <= `alu_res` and `held_i` <= 1.
- Held slot: `rsp_valid[i]` = 1 and `rsp_data_i` = `data_i`. It is cleared at the edge where `rsp_ready[i]` = 1.
- `rsp_valid[i]` never drops without acceptance, and `rsp_data_i` is stable while valid.
- Requesters hold request fields stable while `req_valid` is high and `req_ready` is low. The arbiter does not check this.
- Simultaneous events:
  - A response accepted in the same cycle makes the same requester eligible, which gives back-to-back issue at full throughput.
  - A grant to one requester in the response cycle of the other is legal: `inflight` is overwritten with the new id, while the old result goes out by bypass or into its hold slot.
- Reset (asynchronous, any time): `inflight`, `held_*` and `data_*` go to 0 and `last` goes to `~FIRST_PRIO`. Any in-flight result is dropped.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data*` = 0.
  - `alu_op` = ADD, `alu_a` = `alu_b` = 0.
- Latency: grant at cycle N, so `rsp_valid` rises in cycle N+1. There are no extra cycles when `rsp_ready` = 1.
- Throughput: 1 issue per cycle total. A single requester can reach 1 per cycle if it is always ready.
- Combinational paths:
  - `req_valid`/`rsp_ready` to `req_ready`.
  - `req_*` to `alu_*`.
  - `alu_res` to `rsp_data_i`.
  - No path from `alu_res` to `req_ready`.

## Structure
- Opcode constants (ADD and the rest) come from the shared codes include. Add `ALU_NREQ` = 2 and the idle opcode `ALU_IDLE_OP` = ADD there.
- Sub-module `alu_rsp_slot`: the per-requester bypass/hold register with valid/ready. Instantiate it twice.
- The round-robin pick, `inflight` register and operand mux live in `alu_arbiter`.
- `alu` is instantiated beside `alu_arbiter`, not inside it.

## Test plan
- Reset then a single request: req0 ADD a=5 b=7 held valid, `rsp_ready` = 11 → `req_ready` = 01 in cycle 1, `rsp_valid` = 01 with `rsp_data0` = 12 in cycle 2.
- Contention: both valid every cycle, req0 SUB 10,3 and req1 LT −1,0, `rsp_ready` = 11 → grants alternate 01, 10, 01, …; results 7 and 1 return with correct ids.
- Backpressure: req1 XOR 0xF0,0x0F with `rsp_ready[1]` = 0 for 3 cycles → `rsp_valid[1]` = 1 and `rsp_data1` = 0xFF stable. req1 is not regranted while req0 keeps issuing; it is released when ready returns.
- Back-to-back single requester: req0 valid for 4 cycles (ADD 1+1, 2+2, 3+3, 4+4), ready high → grant every cycle; responses 2, 4, 6, 8 in consecutive cycles.
- Cross-response collision: grant req1 in cycle N and req0 in N+1 with `rsp_ready[1]` = 0 → req1 result held, req0 result bypassed in N+2, both correct.
- Async reset mid-operation: assert `reset_n` = 0 while a result is held and one is in flight → all `rsp_valid`/`req_ready` go to 0 immediately; after release, req1-only traffic is granted first, then `FIRST_PRIO` wins the first contention.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode codes and arbiter-wide constants.
// Opcodes are carried undecoded through the arbiter; only the idle opcode is referenced by name.
package alu_arbiter_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7,
      ALU_LT  = 4'd8,
      ALU_LTU = 4'd9
   } alu_op_e;

   localparam int unsigned ALU_NREQ    = 2;
   localparam logic [3:0]  ALU_IDLE_OP = ALU_ADD;

endpackage

// File: rtl/alu_rsp_slot.sv
// Per-requester response slot: bypasses the ALU result in its response cycle,
// and holds it when the consumer is stalled until the consumer accepts it.
module alu_rsp_slot #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            i_load,
   input  logic            i_ready,
   input  logic [XLEN-1:0] i_res,
   output logic            o_valid,
   output logic [XLEN-1:0] o_data,
   output logic            o_held
);

   logic            r_held;
   logic [XLEN-1:0] r_data;

   // Eligibility upstream guarantees i_load and r_held are never both set.
   always_comb begin
      o_valid = i_load | r_held;
      o_data  = '0;
      if (r_held) begin
         o_data = r_data;
      end else if (i_load) begin
         o_data = i_res;
      end
   end

   assign o_held = r_held;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_held <= 1'b0;
         r_data <= '0;
      end else if (i_load && !i_ready) begin
         r_held <= 1'b1;
         r_data <= i_res;
      end else if (r_held && i_ready) begin
         r_held <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute stage (0)
// and the branch/compare unit (1), routing each result back to its issuer.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned FIRST_PRIO = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ALU_NREQ-1:0] req_valid,
   output logic [ALU_NREQ-1:0] req_ready,
   input  logic [3:0]          req_op0,
   input  logic [3:0]          req_op1,
   input  logic [XLEN-1:0]     req_a0,
   input  logic [XLEN-1:0]     req_b0,
   input  logic [XLEN-1:0]     req_a1,
   input  logic [XLEN-1:0]     req_b1,
   output logic [3:0]          alu_op,
   output logic [XLEN-1:0]     alu_a,
   output logic [XLEN-1:0]     alu_b,
   input  logic [XLEN-1:0]     alu_res,
   output logic [ALU_NREQ-1:0] rsp_valid,
   input  logic [ALU_NREQ-1:0] rsp_ready,
   output logic [XLEN-1:0]     rsp_data0,
   output logic [XLEN-1:0]     rsp_data1
);

   localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

   logic                r_infl_v;
   logic                r_infl_id;
   logic                r_last;
   logic [ALU_NREQ-1:0] w_held;
   logic [ALU_NREQ-1:0] w_load;
   logic [ALU_NREQ-1:0] w_busy;
   logic [ALU_NREQ-1:0] w_elig;
   logic [ALU_NREQ-1:0] w_grant;

   assign w_load = {r_infl_v & r_infl_id, r_infl_v & ~r_infl_id};
   assign w_busy = w_load & ~rsp_ready;
   // Gating with reset_n keeps req_ready low for the whole reset interval.
   assign w_elig = req_valid & ~w_held & ~w_busy & {ALU_NREQ{reset_n}};

   always_comb begin
      w_grant = '0;
      case (w_elig)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
         default: w_grant = '0;
      endcase
   end

   assign req_ready = w_grant;

   always_comb begin
      alu_op = ALU_IDLE_OP;
      alu_a  = '0;
      alu_b  = '0;
      if (w_grant[0]) begin
         alu_op = req_op0;
         alu_a  = req_a0;
         alu_b  = req_b0;
      end else if (w_grant[1]) begin
         alu_op = req_op1;
         alu_a  = req_a1;
         alu_b  = req_b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_infl_v  <= 1'b0;
         r_infl_id <= 1'b0;
         r_last    <= LAST_RST;
      end else begin
         r_infl_v  <= |w_grant;
         r_infl_id <= w_grant[1];
         if (|w_grant) begin
            r_last <= w_grant[1];
         end
      end
   end

   alu_rsp_slot #(.XLEN(XLEN)) u_slot0 (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_load[0]),
      .i_ready (rsp_ready[0]),
      .i_res   (alu_res),
      .o_valid (rsp_valid[0]),
      .o_data  (rsp_data0),
      .o_held  (w_held[0])
   );

   alu_rsp_slot #(.XLEN(XLEN)) u_slot1 (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_load[1]),
      .i_ready (rsp_ready[1]),
      .i_res   (alu_res),
      .o_valid (rsp_valid[1]),
      .o_data  (rsp_data1),
      .o_held  (w_held[1])
   );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU beside it.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [3:0]      req_op0 = '0;
   logic [3:0]      req_op1 = '0;
   logic [XLEN-1:0] req_a0 = '0;
   logic [XLEN-1:0] req_b0 = '0;
   logic [XLEN-1:0] req_a1 = '0;
   logic [XLEN-1:0] req_b1 = '0;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_res = '0;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready = '0;
   logic [XLEN-1:0] rsp_data0;
   logic [XLEN-1:0] rsp_data1;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   alu_arbiter #(.XLEN(XLEN), .FIRST_PRIO(0)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op0   (req_op0),
      .req_op1   (req_op1),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_res   (alu_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data0 (rsp_data0),
      .rsp_data1 (rsp_data1)
   );

   function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd8:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd9:    r = {{(XLEN-1){1'b0}}, (a < b)};
         default: r = '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clock) alu_res <= alu_model(alu_op, alu_a, alu_b);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic chk_out(input string tag, input logic [1:0] e_rdy, input logic [1:0] e_vld,
                          input logic [31:0] e_d0, input logic [31:0] e_d1);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(e_rdy));
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e_vld));
      if (e_vld[0]) chk({tag, ".rsp_data0"}, 64'(rsp_data0), 64'(e_d0));
      if (e_vld[1]) chk({tag, ".rsp_data1"}, 64'(rsp_data1), 64'(e_d1));
   endtask

   initial begin
      logic [1:0]  exp_g;
      logic [1:0]  prev_g;

      // Reset values
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      settle();
      chk("rst.req_ready", 64'(req_ready), 64'(2'b00));
      chk("rst.rsp_valid", 64'(rsp_valid), 64'(2'b00));
      chk("rst.rsp_data0", 64'(rsp_data0), 64'd0);
      chk("rst.rsp_data1", 64'(rsp_data1), 64'd0);
      chk("rst.alu_op", 64'(alu_op), 64'(ALU_IDLE_OP));
      chk("rst.alu_a", 64'(alu_a), 64'd0);
      chk("rst.alu_b", 64'(alu_b), 64'd0);
      req_valid = 2'b00;
      tick();
      tick();
      reset_n = 1'b1;

      // Single request
      req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 32'd5; req_b0 = 32'd7;
      settle();
      chk_out("single.c1", 2'b01, 2'b00, 0, 0);
      chk("single.alu_op", 64'(alu_op), 64'd0);
      chk("single.alu_a", 64'(alu_a), 64'd5);
      chk("single.alu_b", 64'(alu_b), 64'd7);
      tick();
      req_valid = 2'b00;
      settle();
      chk_out("single.c2", 2'b00, 2'b01, 32'd12, 0);
      chk("idle.alu_op", 64'(alu_op), 64'(ALU_IDLE_OP));
      chk("idle.alu_a", 64'(alu_a), 64'd0);
      tick();
      settle();
      chk_out("single.c3", 2'b00, 2'b00, 0, 0);
      tick();

      // Contention: last grant was req0, so req1 goes first
      req_valid = 2'b11;
      req_op0 = 4'd1; req_a0 = 32'd10;         req_b0 = 32'd3;
      req_op1 = 4'd8; req_a1 = 32'hFFFF_FFFF;  req_b1 = 32'd0;
      exp_g  = 2'b10;
      prev_g = 2'b00;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk_out($sformatf("cont.%0d", k), exp_g, prev_g, 32'd7, 32'd1);
         tick();
         prev_g = exp_g;
         exp_g  = ~exp_g;
      end
      req_valid = 2'b00;
      settle();
      chk_out("cont.tail", 2'b00, prev_g, 32'd7, 32'd1);
      tick();

      // Backpressure on req1 while req0 keeps issuing
      req_valid = 2'b11;
      req_op0 = 4'd0; req_a0 = 32'd1;    req_b0 = 32'd2;
      req_op1 = 4'd4; req_a1 = 32'hF0;   req_b1 = 32'h0F;
      rsp_ready = 2'b01;
      settle();
      chk_out("bp.c0", 2'b10, 2'b00, 0, 0);
      tick();
      settle();
      chk_out("bp.c1", 2'b01, 2'b10, 0, 32'hFF);
      tick();
      settle();
      chk_out("bp.c2", 2'b01, 2'b11, 32'd3, 32'hFF);
      tick();
      settle();
      chk_out("bp.c3", 2'b01, 2'b11, 32'd3, 32'hFF);
      tick();
      rsp_ready = 2'b11;
      settle();
      chk_out("bp.c4", 2'b01, 2'b11, 32'd3, 32'hFF);
      tick();
      settle();
      chk_out("bp.c5", 2'b10, 2'b01, 32'd3, 0);
      tick();
      req_valid = 2'b00;
      settle();
      chk_out("bp.c6", 2'b00, 2'b10, 0, 32'hFF);
      tick();

      // Back-to-back single requester
      req_valid = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         req_op0 = 4'd0; req_a0 = 32'(k); req_b0 = 32'(k);
         settle();
         chk_out($sformatf("b2b.%0d", k), 2'b01, (k == 1) ? 2'b00 : 2'b01,
                 32'(2 * (k - 1)), 0);
         tick();
      end
      req_valid = 2'b00;
      settle();
      chk_out("b2b.tail", 2'b00, 2'b01, 32'd8, 0);
      tick();

      // Cross-response collision
      rsp_ready = 2'b01;
      req_valid = 2'b10; req_op1 = 4'd1; req_a1 = 32'd20; req_b1 = 32'd5;
      settle();
      chk_out("coll.n", 2'b10, 2'b00, 0, 0);
      tick();
      req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 32'd100; req_b0 = 32'd23;
      settle();
      chk_out("coll.n1", 2'b01, 2'b10, 0, 32'd15);
      tick();
      req_valid = 2'b00;
      settle();
      chk_out("coll.n2", 2'b00, 2'b11, 32'd123, 32'd15);
      tick();
      settle();
      chk_out("coll.n3", 2'b00, 2'b10, 0, 32'd15);
      rsp_ready = 2'b11;
      tick();
      settle();
      chk_out("coll.n4", 2'b00, 2'b00, 0, 0);
      tick();

      // Async reset with one result held and one in flight
      rsp_ready = 2'b01;
      req_valid = 2'b10; req_op1 = 4'd0; req_a1 = 32'd1; req_b1 = 32'd1;
      tick();
      req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 32'd2; req_b0 = 32'd2;
      tick();
      req_valid = 2'b11;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.rsp_valid", 64'(rsp_valid), 64'(2'b00));
      chk("arst.req_ready", 64'(req_ready), 64'(2'b00));
      chk("arst.rsp_data1", 64'(rsp_data1), 64'd0);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      tick();
      reset_n = 1'b1;
      req_valid = 2'b10; req_op1 = 4'd0; req_a1 = 32'd3; req_b1 = 32'd4;
      settle();
      chk_out("arst.r1only", 2'b10, 2'b00, 0, 0);
      tick();
      req_valid = 2'b11; req_op0 = 4'd1; req_a0 = 32'd9; req_b0 = 32'd4;
      settle();
      chk_out("arst.cont", 2'b01, 2'b10, 0, 32'd7);
      tick();
      req_valid = 2'b00;
      settle();
      chk_out("arst.tail", 2'b00, 2'b01, 32'd5, 0);

      // First contended cycle straight out of reset goes to FIRST_PRIO
      reset_n = 1'b0;
      #1;
      tick();
      reset_n = 1'b1;
      req_valid = 2'b11;
      settle();
      chk("fp.req_ready", 64'(req_ready), 64'(2'b01));
      tick();
      req_valid = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
